// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
//   Bundles the pipeline-side signals seen by the hazard/stall controller.
//   master : pipeline side, drives decode/EX/MEM fields and the memory ack,
//            receives the register enables and stall bookkeeping.
//   slave  : hazard controller, the mirror of master.
//   Signals
//     IDRs1, IDRs2, IDUsesRs2       decode-stage source registers
//     EXRd, EXRegWrite, EXMemRead   ID/EX destination and control
//     BranchTaken                   branch resolved taken in EX
//     MEMAccess, MemAck             EX/MEM load/store and its completion
//     PCWrite .. EXMEMWrite         PC / pipeline register controls
//     StallCount                    saturating count of PC-hold cycles
//     MemTimeout, WaitState         sticky timeout flag, FSM in MEM_WAIT
// ---------------------------------------------------------------------------
interface hazard_ctrl_if #(
  parameter int CNT_WIDTH = 16
);
  logic [2:0]           IDRs1;
  logic [2:0]           IDRs2;
  logic                 IDUsesRs2;
  logic [2:0]           EXRd;
  logic                 EXRegWrite;
  logic                 EXMemRead;
  logic                 BranchTaken;
  logic                 MEMAccess;
  logic                 MemAck;
  logic                 PCWrite;
  logic                 IFIDWrite;
  logic                 IFIDFlush;
  logic                 IDEXWrite;
  logic                 IDEXBubble;
  logic                 EXMEMWrite;
  logic [CNT_WIDTH-1:0] StallCount;
  logic                 MemTimeout;
  logic                 WaitState;

  modport master (
    output IDRs1, IDRs2, IDUsesRs2, EXRd, EXRegWrite, EXMemRead,
           BranchTaken, MEMAccess, MemAck,
    input  PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble, EXMEMWrite,
           StallCount, MemTimeout, WaitState
  );

  modport slave (
    input  IDRs1, IDRs2, IDUsesRs2, EXRd, EXRegWrite, EXMemRead,
           BranchTaken, MEMAccess, MemAck,
    output PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble, EXMEMWrite,
           StallCount, MemTimeout, WaitState
  );
endinterface

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard and stall controller for the 16-bit MISC-V core.
//   Handles multi-cycle data-memory stalls (released by MemAck or by a
//   MAX_WAIT timeout), taken-branch flushes and load-use bubbles, with
//   priority memory stall > branch > load-use.
//   Ports
//     CLK    core clock, all state on the rising edge
//     Reset  synchronous, active-high
//     hz     hazard_ctrl_if.slave: pipeline fields in, register controls
//            and stall bookkeeping out
//   Parameters
//     MAX_WAIT   max MEM_WAIT count before a forced release (2..255)
//     CNT_WIDTH  width of StallCount (must match the interface instance)
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int MAX_WAIT  = 15,
  parameter int CNT_WIDTH = 16
) (
  input logic          CLK,
  input logic          Reset,
  hazard_ctrl_if.slave hz
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [7:0] wait_limit = 8'(MAX_WAIT);

  state_t               state, state_nxt;
  logic [7:0]           wait_cnt, wait_cnt_nxt;
  logic                 timeout_hit;
  logic [CNT_WIDTH-1:0] stall_count;
  logic                 mem_timeout;

  logic mem_stall;
  logic load_use;
  logic pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write;

  // Memory stall: first cycle of an un-acked access in RUN, then every
  // MEM_WAIT cycle until the ack or until the wait counter reaches the limit.
  assign mem_stall = ((state == RUN)      && hz.MEMAccess && !hz.MemAck) ||
                     ((state == MEM_WAIT) && !hz.MemAck && (wait_cnt != wait_limit));

  // r0 is hardwired zero, so a load targeting it can never create a hazard.
  assign load_use = hz.EXMemRead && hz.EXRegWrite && (hz.EXRd != 3'd0) &&
                    ((hz.EXRd == hz.IDRs1) || (hz.IDUsesRs2 && (hz.EXRd == hz.IDRs2)));

  // State register plus the counters and sticky flag.
  // NOTE: reset is synchronous, so it lives inside the clocked block and is
  // only seen at a rising edge.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state       <= RUN;
      wait_cnt    <= 8'd0;
      stall_count <= '0;
      mem_timeout <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (!pc_write && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
      if (timeout_hit)
        mem_timeout <= 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned, which
    // would otherwise infer a latch.
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    timeout_hit  = 1'b0;
    case (state)
      RUN: begin
        if (hz.MEMAccess && !hz.MemAck) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (hz.MemAck) begin
          state_nxt    = RUN;
          wait_cnt_nxt = 8'd0;
        end else if (wait_cnt == wait_limit) begin
          // Forced release: the stall is already dropped this cycle.
          state_nxt    = RUN;
          wait_cnt_nxt = 8'd0;
          timeout_hit  = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
    endcase
  end

  // Output logic. A branch or load-use seen during a memory stall is simply
  // held in EX and gets acted on once the stall drops.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_bubble = 1'b0;
    exmem_write = 1'b1;
    if (!Reset) begin
      if (mem_stall) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_write  = 1'b0;
        exmem_write = 1'b0;
      end else if (hz.BranchTaken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (load_use) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

  assign hz.PCWrite    = pc_write;
  assign hz.IFIDWrite  = ifid_write;
  assign hz.IFIDFlush  = ifid_flush;
  assign hz.IDEXWrite  = idex_write;
  assign hz.IDEXBubble = idex_bubble;
  assign hz.EXMEMWrite = exmem_write;
  assign hz.StallCount = stall_count;
  assign hz.MemTimeout = mem_timeout;
  assign hz.WaitState  = (state == MEM_WAIT);

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//   Self-checking bench for hazard_ctrl (MAX_WAIT=15, CNT_WIDTH=4).
//   Table of single-cycle vectors from a fresh reset, followed by directed
//   multi-cycle sequences: load-use, acked memory stall, timeout with
//   counter saturation, branch behind a memory stall, reset mid-wait.
//   Control outputs are packed as {PCWrite, IFIDWrite, IFIDFlush,
//   IDEXWrite, IDEXBubble, EXMEMWrite}.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam logic [5:0] OUT_NORMAL = 6'b110101;
  localparam logic [5:0] OUT_LOADUS = 6'b000111;
  localparam logic [5:0] OUT_BRANCH = 6'b111111;
  localparam logic [5:0] OUT_STALL  = 6'b000000;

  typedef struct {
    logic       rst;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic       uses_rs2;
    logic [2:0] ex_rd;
    logic       ex_rw;
    logic       ex_mr;
    logic       br;
    logic       mem;
    logic       ack;
    logic [5:0] exp_out;
    logic       exp_wait;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  hazard_ctrl_if #(.CNT_WIDTH(4)) hz ();

  hazard_ctrl #(
    .MAX_WAIT (15),
    .CNT_WIDTH(4)
  ) dut (
    .CLK  (clk),
    .Reset(rst),
    .hz   (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [5:0] outs();
    return {hz.PCWrite, hz.IFIDWrite, hz.IFIDFlush, hz.IDEXWrite, hz.IDEXBubble, hz.EXMEMWrite};
  endfunction

  task automatic idle();
    hz.IDRs1       = 3'd0;
    hz.IDRs2       = 3'd0;
    hz.IDUsesRs2   = 1'b0;
    hz.EXRd        = 3'd0;
    hz.EXRegWrite  = 1'b0;
    hz.EXMemRead   = 1'b0;
    hz.BranchTaken = 1'b0;
    hz.MEMAccess   = 1'b0;
    hz.MemAck      = 1'b0;
  endtask

  // Ends on a falling edge with Reset low and inputs idle.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_use_in(input logic [2:0] rd);
    hz.EXMemRead  = 1'b1;
    hz.EXRegWrite = 1'b1;
    hz.EXRd       = rd;
    hz.IDRs1      = rd;
  endtask

  vec_t vecs[14];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    idle();

    //            rst  rs1   rs2   u2   rd    rw   mr   br   mem  ack  outputs      wait
    vecs[0]  = '{1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, OUT_NORMAL, 1'b0};
    vecs[1]  = '{1'b0, 3'd3, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, OUT_LOADUS, 1'b0};
    vecs[2]  = '{1'b0, 3'd0, 3'd0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, OUT_NORMAL, 1'b0};
    vecs[3]  = '{1'b0, 3'd1, 3'd5, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, OUT_NORMAL, 1'b0};
    vecs[4]  = '{1'b0, 3'd1, 3'd5, 1'b1, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, OUT_LOADUS, 1'b0};
    vecs[5]  = '{1'b0, 3'd3, 3'd0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, OUT_NORMAL, 1'b0};
    vecs[6]  = '{1'b0, 3'd3, 3'd2, 1'b1, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, OUT_NORMAL, 1'b0};
    vecs[7]  = '{1'b0, 3'd3, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, OUT_NORMAL, 1'b0};
    vecs[8]  = '{1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, OUT_BRANCH, 1'b0};
    vecs[9]  = '{1'b0, 3'd3, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, OUT_BRANCH, 1'b0};
    vecs[10] = '{1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, OUT_STALL,  1'b1};
    vecs[11] = '{1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, OUT_NORMAL, 1'b0};
    vecs[12] = '{1'b0, 3'd3, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, OUT_STALL,  1'b1};
    vecs[13] = '{1'b1, 3'd3, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, OUT_NORMAL, 1'b0};

    // Reset state
    do_reset();
    #2;
    check("reset_outs",    16'(outs()),         16'(OUT_NORMAL));
    check("reset_wait",    16'(hz.WaitState),   16'd0);
    check("reset_count",   16'(hz.StallCount),  16'd0);
    check("reset_timeout", 16'(hz.MemTimeout),  16'd0);

    // Table-driven single-cycle vectors, each from a fresh reset
    for (int i = 0; i < 14; i++) begin
      do_reset();
      rst            = vecs[i].rst;
      hz.IDRs1       = vecs[i].rs1;
      hz.IDRs2       = vecs[i].rs2;
      hz.IDUsesRs2   = vecs[i].uses_rs2;
      hz.EXRd        = vecs[i].ex_rd;
      hz.EXRegWrite  = vecs[i].ex_rw;
      hz.EXMemRead   = vecs[i].ex_mr;
      hz.BranchTaken = vecs[i].br;
      hz.MEMAccess   = vecs[i].mem;
      hz.MemAck      = vecs[i].ack;
      #2;
      check($sformatf("vec%0d_outs", i), 16'(outs()), 16'(vecs[i].exp_out));
      @(negedge clk);
      #2;
      check($sformatf("vec%0d_count", i), 16'(hz.StallCount), 16'(!vecs[i].exp_out[5]));
      check($sformatf("vec%0d_wait", i),  16'(hz.WaitState),  16'(vecs[i].exp_wait));
      rst = 1'b0;
    end

    // Load-use for one cycle, then the bubble clears it
    do_reset();
    load_use_in(3'd3);
    #2;
    check("lu_stall_outs", 16'(outs()), 16'(OUT_LOADUS));
    @(negedge clk);
    hz.EXMemRead = 1'b0;
    #2;
    check("lu_bubble_outs", 16'(outs()), 16'(OUT_NORMAL));
    @(negedge clk);
    #2;
    check("lu_count", 16'(hz.StallCount), 16'd1);

    // Memory access acked 4 cycles after it first appears
    do_reset();
    hz.MEMAccess = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      check($sformatf("ack_stall%0d_outs", i), 16'(outs()), 16'(OUT_STALL));
      check($sformatf("ack_stall%0d_wait", i), 16'(hz.WaitState), 16'(i != 0));
      @(negedge clk);
    end
    hz.MemAck = 1'b1;
    #2;
    check("ack_release_outs", 16'(outs()), 16'(OUT_NORMAL));
    check("ack_release_wait", 16'(hz.WaitState), 16'd1);
    @(negedge clk);
    idle();
    #2;
    check("ack_after_wait",    16'(hz.WaitState),  16'd0);
    check("ack_after_count",   16'(hz.StallCount), 16'd4);
    check("ack_after_timeout", 16'(hz.MemTimeout), 16'd0);

    // No ack: 15 stalled cycles, forced release, sticky timeout, saturation
    do_reset();
    hz.MEMAccess = 1'b1;
    for (int i = 0; i < 15; i++) begin
      #2;
      check($sformatf("to_stall%0d_outs", i), 16'(outs()), 16'(OUT_STALL));
      @(negedge clk);
    end
    #2;
    check("to_release_outs",    16'(outs()), 16'(OUT_NORMAL));
    check("to_release_wait",    16'(hz.WaitState), 16'd1);
    check("to_release_timeout", 16'(hz.MemTimeout), 16'd0);
    @(negedge clk);
    idle();
    #2;
    check("to_after_timeout", 16'(hz.MemTimeout), 16'd1);
    check("to_after_wait",    16'(hz.WaitState),  16'd0);
    check("to_after_count",   16'(hz.StallCount), 16'd15);
    load_use_in(3'd2);
    #2;
    check("sat_lu_outs", 16'(outs()), 16'(OUT_LOADUS));
    @(negedge clk);
    idle();
    #2;
    check("sat_count",      16'(hz.StallCount), 16'd15);
    check("sticky_timeout", 16'(hz.MemTimeout), 16'd1);
    do_reset();
    #2;
    check("timeout_cleared", 16'(hz.MemTimeout), 16'd0);
    check("count_cleared",   16'(hz.StallCount), 16'd0);

    // Branch plus load-use held behind a memory stall
    do_reset();
    hz.MEMAccess   = 1'b1;
    hz.BranchTaken = 1'b1;
    load_use_in(3'd3);
    for (int i = 0; i < 3; i++) begin
      #2;
      check($sformatf("brs_stall%0d_outs", i), 16'(outs()), 16'(OUT_STALL));
      @(negedge clk);
    end
    hz.MemAck = 1'b1;
    #2;
    check("brs_ack_outs", 16'(outs()), 16'(OUT_BRANCH));
    @(negedge clk);
    idle();
    #2;
    check("brs_after_outs",  16'(outs()), 16'(OUT_NORMAL));
    check("brs_after_wait",  16'(hz.WaitState),  16'd0);
    check("brs_after_count", 16'(hz.StallCount), 16'd3);

    // Reset during the 3rd MEM_WAIT cycle
    do_reset();
    hz.MEMAccess = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    rst = 1'b1;
    #2;
    check("rmw_forced_outs", 16'(outs()), 16'(OUT_NORMAL));
    check("rmw_pre_wait",    16'(hz.WaitState), 16'd1);
    @(negedge clk);
    rst = 1'b0;
    idle();
    #2;
    check("rmw_wait",    16'(hz.WaitState),  16'd0);
    check("rmw_count",   16'(hz.StallCount), 16'd0);
    check("rmw_outs",    16'(outs()),        16'(OUT_NORMAL));
    check("rmw_timeout", 16'(hz.MemTimeout), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
